soc_system_pio_key_in: RTL and testbench



---
 rtl/soc_system_pio_pkg.sv | 18 +
 rtl/soc_system_pio_key_in_if.sv | 23 ++
 rtl/soc_system_pio_debounce.sv | 72 +++++++
 rtl/soc_system_pio_key_in.sv | 98 +++++++++
 tb/tb_soc_system_pio_key_in.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_system_pio_pkg.sv
// rtl/soc_system_pio_pkg.sv - shared constants for the key input PIO
// Purpose: register word addresses and edge-type encodings used by the
//          key input PIO and its debouncer.
// Ports:   none (package).
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/soc_system_pio_key_in_if.sv
// rtl/soc_system_pio_key_in_if.sv - Avalon-MM slave bus bundle for the key PIO
// Purpose: groups the register bus signals of the key input PIO.
// Ports:   address/chipselect/write_n/writedata driven by the master,
//          readdata driven by the slave (read latency 1).
interface soc_system_pio_key_in_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/soc_system_pio_debounce.sv
// rtl/soc_system_pio_debounce.sv - input synchronizer and optional debouncer
// Purpose: 2-flop synchronizer on every bit followed by either a plain
//          register (DEBOUNCE_CYCLES=0) or a tick-sampled debouncer.
// Ports:   clk, reset_n (async, active-low), in_port (async inputs),
//          db (debounced level), db_next (value db takes on the next edge).
module soc_system_pio_debounce #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] IN_RESET_LEVEL  = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] db,
  output logic [WIDTH-1:0] db_next
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] db_q;
  logic [WIDTH-1:0] db_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IN_RESET_LEVEL;
      sync2_q <= IN_RESET_LEVEL;
      db_q    <= IN_RESET_LEVEL;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      db_q    <= db_d;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign db_d = sync2_q;
    end else begin : g_debounce
      localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0]    cnt_q;
      logic [CW-1:0]    cnt_d;
      logic             tick;
      logic [WIDTH-1:0] samp_q;
      logic [WIDTH-1:0] samp_d;
      logic [WIDTH-1:0] stable;

      assign tick   = (cnt_q == TERM);
      assign cnt_d  = tick ? '0 : cnt_q + 1'b1;
      assign samp_d = tick ? sync2_q : samp_q;
      // A bit is accepted only when it matches the level seen at the
      // previous tick, so anything shorter than a tick period is dropped.
      assign stable = ~(sync2_q ^ samp_q);
      assign db_d   = tick ? ((db_q & ~stable) | (sync2_q & stable)) : db_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q  <= '0;
          samp_q <= IN_RESET_LEVEL;
        end else begin
          cnt_q  <= cnt_d;
          samp_q <= samp_d;
        end
      end
    end
  endgenerate

  assign db      = db_q;
  assign db_next = db_d;

endmodule

// File: rtl/soc_system_pio_key_in.sv
// rtl/soc_system_pio_key_in.sv - key/switch input PIO with edge capture and irq
// Purpose: Avalon-MM slave input PIO. Synchronizes/debounces in_port,
//          captures edges into a sticky write-1-to-clear register and raises
//          a maskable level interrupt.
// Ports:   clk, reset_n (async, active-low), bus (slave register port:
//          0 DATA, 1 IRQ_MASK, 2 reserved, 3 EDGE_CAP), in_port (async
//          inputs), irq (active-high level interrupt).
module soc_system_pio_key_in
  import soc_system_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               EDGE_TYPE       = 1,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] IN_RESET_LEVEL  = '1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  soc_system_pio_key_in_if.slave   bus,
  input  logic [WIDTH-1:0]         in_port,
  output logic                     irq
);

  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edge_cap_q;
  logic [WIDTH-1:0] edge_cap_d;
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] irq_mask_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  soc_system_pio_debounce #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .IN_RESET_LEVEL (IN_RESET_LEVEL)
  ) u_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .db     (db),
    .db_next(db_next)
  );

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign unused_wdata = ^bus.writedata;

  // Edges are detected against db_next so the capture bit rises on the
  // same edge that db changes.
  always_comb begin
    rise = ~db & db_next;
    fall = db & ~db_next;
    case (EDGE_TYPE)
      int'(EDGE_RISE): ev = rise;
      int'(EDGE_ANY):  ev = rise | fall;
      default:         ev = fall;
    endcase
  end

  // A new edge and a write-1-clear on the same bit leave the bit set.
  always_comb begin
    clr        = (wr_en && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
    edge_cap_d = (edge_cap_q & ~clr) | ev;
    irq_mask_d = (wr_en && bus.address == ADDR_MASK) ? bus.writedata[WIDTH-1:0] : irq_mask_q;
  end

  // Read mux is sampled every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = db;
      ADDR_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_cap_q;
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap_q <= '0;
      irq_mask_q <= '0;
      readdata_q <= '0;
    end else begin
      edge_cap_q <= edge_cap_d;
      irq_mask_q <= irq_mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_soc_system_pio_key_in.sv
// tb/tb_soc_system_pio_key_in.sv - self-checking bench for the key input PIO
module tb_soc_system_pio_key_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        cs = 1'b0;
  logic        wn = 1'b1;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  in_port = 4'hF;
  logic [2:0]  irq_o;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  soc_system_pio_key_in_if bus0 ();
  soc_system_pio_key_in_if bus1 ();
  soc_system_pio_key_in_if bus2 ();

  assign bus0.address = addr; assign bus0.chipselect = cs; assign bus0.write_n = wn; assign bus0.writedata = wdata;
  assign bus1.address = addr; assign bus1.chipselect = cs; assign bus1.write_n = wn; assign bus1.writedata = wdata;
  assign bus2.address = addr; assign bus2.chipselect = cs; assign bus2.write_n = wn; assign bus2.writedata = wdata;

  // dut0: falling edge, no debounce; dut1: falling edge, 8-cycle debounce;
  // dut2: any edge, no debounce.
  soc_system_pio_key_in #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0), .IN_RESET_LEVEL(4'hF))
    dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq_o[0]));
  soc_system_pio_key_in #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(8), .IN_RESET_LEVEL(4'hF))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port), .irq(irq_o[1]));
  soc_system_pio_key_in #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0), .IN_RESET_LEVEL(4'hF))
    dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port), .irq(irq_o[2]));

  logic [31:0] rd_o  [3];
  logic [3:0]  cap_o [3];
  logic [3:0]  db_o  [3];
  assign rd_o[0] = bus0.readdata;  assign rd_o[1] = bus1.readdata;  assign rd_o[2] = bus2.readdata;
  assign cap_o[0] = dut0.edge_cap_q; assign cap_o[1] = dut1.edge_cap_q; assign cap_o[2] = dut2.edge_cap_q;
  assign db_o[0] = dut0.db; assign db_o[1] = dut1.db; assign db_o[2] = dut2.db;

  // Reference model: keeps the history of in_port as seen at each clock
  // edge since reset and derives db from that history directly.
  function automatic int dbc(int c); return (c == 1) ? 8 : 0; endfunction
  function automatic int etype(int c); return (c == 2) ? 2 : 1; endfunction

  logic [3:0]  ring [64];
  int          n;
  logic [3:0]  m_db   [3];
  logic [3:0]  m_cap  [3];
  logic [3:0]  m_mask [3];
  logic [31:0] m_rd   [3];

  function automatic logic [3:0] hist(int k);
    return (k < 1) ? 4'hF : ring[k % 64];
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    logic [3:0] s2, nxt, ev, clr, stab;
    if (!reset_n) begin
      n = 0;
      for (int c = 0; c < 3; c++) begin
        m_db[c] = 4'hF; m_cap[c] = 4'h0; m_mask[c] = 4'h0; m_rd[c] = 32'h0;
      end
    end else begin
      n = n + 1;
      ring[n % 64] = in_port;
      for (int c = 0; c < 3; c++) begin
        s2 = hist(n - 2);
        if (dbc(c) == 0) nxt = s2;
        else if (n % dbc(c) == 0) begin
          stab = ~(s2 ^ hist(n - 2 - dbc(c)));
          nxt  = (m_db[c] & ~stab) | (s2 & stab);
        end else nxt = m_db[c];
        if (etype(c) == 0) ev = ~m_db[c] & nxt;
        else if (etype(c) == 1) ev = m_db[c] & ~nxt;
        else ev = m_db[c] ^ nxt;
        clr = (cs && !wn && addr == 2'd3) ? wdata[3:0] : 4'h0;
        case (addr)
          2'd0: m_rd[c] = {28'h0, m_db[c]};
          2'd1: m_rd[c] = {28'h0, m_mask[c]};
          2'd3: m_rd[c] = {28'h0, m_cap[c]};
          default: m_rd[c] = 32'h0;
        endcase
        m_cap[c] = (m_cap[c] & ~clr) | ev;
        if (cs && !wn && addr == 2'd1) m_mask[c] = wdata[3:0];
        m_db[c] = nxt;
      end
    end
  end

  task automatic cyc(int k); repeat (k) @(negedge clk); endtask

  task automatic bus_write(logic [1:0] a, logic [31:0] d);
    addr = a; cs = 1'b1; wn = 1'b0; wdata = d;
    cyc(1);
    cs = 1'b0; wn = 1'b1;
  endtask

  task automatic test_reset;
    cyc(3);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rd_o[c] !== 32'h0 || irq_o[c] !== 1'b0 || cap_o[c] !== 4'h0 || db_o[c] !== 4'hF) begin
        errors++;
        $display("FAIL reset_state dut%0d rd=%h irq=%b cap=%h db=%h exp rd=0 irq=0 cap=0 db=F", c, rd_o[c], irq_o[c], cap_o[c], db_o[c]);
      end
    end
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      logic [31:0] exp;
      addr = 2'(a); cs = 1'b1;
      cyc(1);
      exp = (a == 0) ? 32'h0000000F : 32'h0;
      checks++;
      if (rd_o[0] !== exp) begin
        errors++; $display("FAIL reset_read addr%0d got=%h exp=%h", a, rd_o[0], exp);
      end
    end
    cs = 1'b0; addr = 2'd0;
    checks++;
    if (irq_o[0] !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_o[0]); end
  endtask

  task automatic test_fall_capture;
    bus_write(2'd1, 32'h2);
    in_port = 4'hD;
    cyc(2);
    checks++;
    if (cap_o[0] !== 4'h0) begin errors++; $display("FAIL fall_early cap=%h exp=0", cap_o[0]); end
    cyc(1);
    checks++;
    if (cap_o[0] !== 4'h2 || irq_o[0] !== 1'b1) begin
      errors++; $display("FAIL fall_third_edge cap=%h irq=%b exp cap=2 irq=1", cap_o[0], irq_o[0]);
    end
    addr = 2'd3; cs = 1'b1;
    cyc(1);
    cs = 1'b0;
    checks++;
    if (rd_o[0] !== 32'h2) begin errors++; $display("FAIL fall_read_cap got=%h exp=2", rd_o[0]); end
    bus_write(2'd3, 32'h2);
    checks++;
    if (cap_o[0] !== 4'h0 || irq_o[0] !== 1'b0) begin
      errors++; $display("FAIL fall_clear cap=%h irq=%b exp cap=0 irq=0", cap_o[0], irq_o[0]);
    end
  endtask

  task automatic test_mask_gating;
    bus_write(2'd1, 32'h0);
    in_port = 4'hC;
    cyc(3);
    checks++;
    if (cap_o[0] !== 4'h1 || irq_o[0] !== 1'b0) begin
      errors++; $display("FAIL mask_off cap=%h irq=%b exp cap=1 irq=0", cap_o[0], irq_o[0]);
    end
    bus_write(2'd1, 32'h1);
    checks++;
    if (irq_o[0] !== 1'b1) begin errors++; $display("FAIL mask_on irq=%b exp=1", irq_o[0]); end
    bus_write(2'd1, 32'h0);
    checks++;
    if (irq_o[0] !== 1'b0) begin errors++; $display("FAIL mask_reoff irq=%b exp=0", irq_o[0]); end
  endtask

  task automatic test_collision;
    bus_write(2'd3, 32'hF);
    in_port = 4'h8;
    cyc(2);
    bus_write(2'd3, 32'h4);
    checks++;
    if (cap_o[0] !== 4'h4) begin errors++; $display("FAIL collision cap=%h exp=4", cap_o[0]); end
  endtask

  task automatic test_debounce;
    int bad, lat, rises;
    logic prev;
    in_port = 4'hF;
    cyc(40);
    bus_write(2'd3, 32'hF);
    checks++;
    if (db_o[1] !== 4'hF || cap_o[1] !== 4'h0) begin
      errors++; $display("FAIL deb_idle db=%h cap=%h exp db=F cap=0", db_o[1], cap_o[1]);
    end
    bad = 0;
    in_port = 4'hE;
    for (int i = 0; i < 35; i++) begin
      if (i == 5) in_port = 4'hF;
      cyc(1);
      if (db_o[1] !== 4'hF || cap_o[1] !== 4'h0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL deb_glitch bad_cycles=%0d exp=0", bad); end
    in_port = 4'hE;
    lat = 0; rises = 0; prev = cap_o[1][0];
    while (db_o[1][0] !== 1'b0 && lat < 40) begin
      cyc(1); lat++;
      if (cap_o[1][0] === 1'b1 && prev !== 1'b1) rises++;
      prev = cap_o[1][0];
    end
    checks++;
    if (lat > 19) begin errors++; $display("FAIL deb_latency cycles=%0d exp<=19", lat); end
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (cap_o[1][0] === 1'b1 && prev !== 1'b1) rises++;
      prev = cap_o[1][0];
    end
    checks++;
    if (rises != 1) begin errors++; $display("FAIL deb_once captures=%0d exp=1", rises); end
  endtask

  task automatic test_any_edge;
    in_port = 4'hF;
    cyc(5);
    bus_write(2'd3, 32'hF);
    checks++;
    if (cap_o[2] !== 4'h0) begin errors++; $display("FAIL any_clear0 cap=%h exp=0", cap_o[2]); end
    in_port = 4'h7;
    cyc(3);
    checks++;
    if (cap_o[2] !== 4'h8) begin errors++; $display("FAIL any_fall cap=%h exp=8", cap_o[2]); end
    bus_write(2'd3, 32'h8);
    checks++;
    if (cap_o[2] !== 4'h0) begin errors++; $display("FAIL any_clear1 cap=%h exp=0", cap_o[2]); end
    in_port = 4'hF;
    cyc(3);
    checks++;
    if (cap_o[2] !== 4'h8) begin errors++; $display("FAIL any_rise cap=%h exp=8", cap_o[2]); end
  endtask

  task automatic test_reset_mid;
    bus_write(2'd1, 32'hF);
    in_port = 4'h7;
    cyc(1);
    #2 reset_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (cap_o[c] !== 4'h0 || db_o[c] !== 4'hF || rd_o[c] !== 32'h0 || irq_o[c] !== 1'b0) begin
        errors++;
        $display("FAIL midreset dut%0d cap=%h db=%h rd=%h irq=%b exp cap=0 db=F rd=0 irq=0", c, cap_o[c], db_o[c], rd_o[c], irq_o[c]);
      end
    end
    in_port = 4'hF;
    cyc(3);
    reset_n = 1'b1;
    cyc(12);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (cap_o[c] !== 4'h0 || db_o[c] !== 4'hF) begin
        errors++; $display("FAIL post_reset dut%0d cap=%h db=%h exp cap=0 db=F", c, cap_o[c], db_o[c]);
      end
    end
  endtask

  task automatic test_random;
    int bad [3];
    for (int c = 0; c < 3; c++) bad[c] = 0;
    for (int i = 0; i < 600; i++) begin
      if (i > 0)
        for (int c = 0; c < 3; c++)
          if (rd_o[c] !== m_rd[c] || cap_o[c] !== m_cap[c] || db_o[c] !== m_db[c] ||
              irq_o[c] !== |(m_cap[c] & m_mask[c])) begin
            if (bad[c] < 3)
              $display("FAIL random dut%0d cyc=%0d rd=%h/%h cap=%h/%h db=%h/%h irq=%b (got/exp)",
                       c, i, rd_o[c], m_rd[c], cap_o[c], m_cap[c], db_o[c], m_db[c], irq_o[c]);
            bad[c]++;
          end
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, 3);
        in_port[b] = ~in_port[b];
      end
      addr  = 2'($urandom_range(0, 3));
      cs    = 1'($urandom_range(0, 1));
      wn    = ($urandom_range(0, 3) != 0);
      wdata = $urandom;
      cyc(1);
    end
    cs = 1'b0; wn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bad[c] != 0) begin errors++; $display("FAIL random_total dut%0d bad_cycles=%0d exp=0", c, bad[c]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fall_capture();
    test_mask_gating();
    test_collision();
    test_debounce();
    test_any_edge();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
